// File: rtl/alu_operand_reg.sv
// rtl/alu_operand_reg.sv - loadable, shiftable ALU operand register with valid handshake
module alu_operand_reg #(
    parameter int               WIDTH     = 8,
    parameter int               NUM_SRC   = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data,
    input  logic [NUM_SRC-1:0]         src_load,
    input  logic                       invert,
    input  logic                       clear,
    input  logic                       shift_en,
    input  logic                       shift_dir,
    input  logic                       shift_in,
    input  logic                       consume,
    output logic [WIDTH-1:0]           out,
    output logic                       shift_out,
    output logic                       valid,
    output logic                       conflict
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             shift_out_q, shift_out_d;
    logic             valid_q, valid_d;
    logic             conflict_q, conflict_d;

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic             any_load;
    logic             multi_load;
    logic             eject_bit;

    assign any_load   = |src_load;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_load = |(src_load & (src_load - NUM_SRC'(1)));
    assign eject_bit  = shift_dir ? out_q[0] : out_q[WIDTH-1];

    // Walk from the top down so the lowest asserted source wins.
    always_comb begin
        sel_data = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_load[i]) begin
                sel_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign shl_val = shift_in;
            assign shr_val = shift_in;
        end else begin : g_shift_wn
            assign shl_val = {out_q[WIDTH-2:0], shift_in};
            assign shr_val = {shift_in, out_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        out_d       = out_q;
        shift_out_d = shift_out_q;
        valid_d     = valid_q;
        conflict_d  = conflict_q | multi_load;

        if (clear) begin
            out_d   = '0;
            valid_d = 1'b0;
        end else if (any_load) begin
            out_d   = invert ? ~sel_data : sel_data;
            valid_d = 1'b1;
        end else begin
            if (shift_en) begin
                out_d       = shift_dir ? shr_val : shl_val;
                shift_out_d = eject_bit;
            end
            if (consume) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= RESET_VAL;
            shift_out_q <= 1'b0;
            valid_q     <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            shift_out_q <= shift_out_d;
            valid_q     <= valid_d;
            conflict_q  <= conflict_d;
        end
    end

    assign out       = out_q;
    assign shift_out = shift_out_q;
    assign valid     = valid_q;
    assign conflict  = conflict_q;

endmodule

// File: tb/tb_alu_operand_reg.sv
// tb/tb_alu_operand_reg.sv - directed checks of alu_operand_reg at three parameter sets
module tb_alu_operand_reg;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance: WIDTH=8, NUM_SRC=3
    logic [23:0] a_src_data;
    logic [2:0]  a_src_load;
    logic        a_invert, a_clear, a_shift_en, a_shift_dir, a_shift_in, a_consume;
    logic [7:0]  a_out;
    logic        a_shift_out, a_valid, a_conflict;

    alu_operand_reg u_a (
        .clk(clk), .reset(reset), .src_data(a_src_data), .src_load(a_src_load),
        .invert(a_invert), .clear(a_clear), .shift_en(a_shift_en), .shift_dir(a_shift_dir),
        .shift_in(a_shift_in), .consume(a_consume), .out(a_out), .shift_out(a_shift_out),
        .valid(a_valid), .conflict(a_conflict)
    );

    // WIDTH=1, NUM_SRC=1, RESET_VAL=1
    logic b_src_data, b_src_load;
    logic b_invert, b_clear, b_shift_en, b_shift_dir, b_shift_in, b_consume;
    logic b_out, b_shift_out, b_valid, b_conflict;

    alu_operand_reg #(.WIDTH(1), .NUM_SRC(1), .RESET_VAL(1'b1)) u_b (
        .clk(clk), .reset(reset), .src_data(b_src_data), .src_load(b_src_load),
        .invert(b_invert), .clear(b_clear), .shift_en(b_shift_en), .shift_dir(b_shift_dir),
        .shift_in(b_shift_in), .consume(b_consume), .out(b_out), .shift_out(b_shift_out),
        .valid(b_valid), .conflict(b_conflict)
    );

    // WIDTH=16, NUM_SRC=8
    logic [127:0] c_src_data;
    logic [7:0]   c_src_load;
    logic         c_invert, c_clear, c_shift_en, c_shift_dir, c_shift_in, c_consume;
    logic [15:0]  c_out;
    logic         c_shift_out, c_valid, c_conflict;

    alu_operand_reg #(.WIDTH(16), .NUM_SRC(8)) u_c (
        .clk(clk), .reset(reset), .src_data(c_src_data), .src_load(c_src_load),
        .invert(c_invert), .clear(c_clear), .shift_en(c_shift_en), .shift_dir(c_shift_dir),
        .shift_in(c_shift_in), .consume(c_consume), .out(c_out), .shift_out(c_shift_out),
        .valid(c_valid), .conflict(c_conflict)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_src_load = '0; a_invert = 0; a_clear = 0; a_shift_en = 0;
        a_shift_dir = 0; a_shift_in = 0; a_consume = 0;
        b_src_load = '0; b_invert = 0; b_clear = 0; b_shift_en = 0;
        b_shift_dir = 0; b_shift_in = 0; b_consume = 0;
        c_src_load = '0; c_invert = 0; c_clear = 0; c_shift_en = 0;
        c_shift_dir = 0; c_shift_in = 0; c_consume = 0;
    endtask

    initial begin
        a_src_data = '0; b_src_data = 0; c_src_data = '0;
        idle_all();
        reset = 1'b0;
        #12;
        chk("rst_a_out", 32'(a_out), 32'h00);
        chk("rst_a_valid", 32'(a_valid), 32'h0);
        chk("rst_a_conflict", 32'(a_conflict), 32'h0);
        chk("rst_a_shift_out", 32'(a_shift_out), 32'h0);
        chk("rst_b_out", 32'(b_out), 32'h1);
        chk("rst_c_out", 32'(c_out), 32'h0000);
        reset = 1'b1;
        tick();

        // load 0x5A then reset asynchronously between edges
        a_src_data = 24'h00_00_5A; a_src_load = 3'b001;
        tick();
        chk("ld5a_out", 32'(a_out), 32'h5A);
        chk("ld5a_valid", 32'(a_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_out", 32'(a_out), 32'h00);
        chk("async_rst_valid", 32'(a_valid), 32'h0);
        chk("async_rst_conflict", 32'(a_conflict), 32'h0);
        // load held through an edge while in reset is discarded
        tick();
        chk("rst_hold_out", 32'(a_out), 32'h00);
        a_src_load = 3'b000;
        reset = 1'b1;
        tick();
        chk("post_rst_out", 32'(a_out), 32'h00);

        // load with invert, then consume
        a_src_data = 24'h00_3C_00; a_src_load = 3'b010; a_invert = 1;
        tick();
        chk("inv_out", 32'(a_out), 32'hC3);
        chk("inv_valid", 32'(a_valid), 32'h1);
        a_src_load = 3'b000; a_consume = 1;
        tick();
        chk("consume_valid", 32'(a_valid), 32'h0);
        chk("consume_out", 32'(a_out), 32'hC3);
        a_invert = 0;
        tick();
        chk("consume_noop_valid", 32'(a_valid), 32'h0);
        a_consume = 0;

        // multi-source load: lowest index wins, conflict sticks through clear
        a_src_data = 24'h22_11_99; a_src_load = 3'b110;
        tick();
        chk("conf_out", 32'(a_out), 32'h11);
        chk("conf_flag", 32'(a_conflict), 32'h1);
        chk("conf_valid", 32'(a_valid), 32'h1);
        a_clear = 1; a_src_load = 3'b001;
        tick();
        chk("clr_out", 32'(a_out), 32'h00);
        chk("clr_valid", 32'(a_valid), 32'h0);
        chk("clr_conflict", 32'(a_conflict), 32'h1);
        a_clear = 0; a_src_load = 3'b000;

        // shifts
        a_src_data = 24'h00_00_81; a_src_load = 3'b001;
        tick();
        a_src_load = 3'b000; a_shift_en = 1; a_shift_dir = 0; a_shift_in = 0;
        tick();
        chk("shl_out", 32'(a_out), 32'h02);
        chk("shl_so", 32'(a_shift_out), 32'h1);
        chk("shl_valid", 32'(a_valid), 32'h1);
        a_shift_dir = 1; a_shift_in = 1;
        tick();
        chk("shr_out", 32'(a_out), 32'h81);
        chk("shr_so", 32'(a_shift_out), 32'h0);
        chk("shr_valid", 32'(a_valid), 32'h1);
        a_shift_en = 0; a_invert = 1;
        tick();
        chk("hold_out", 32'(a_out), 32'h81);
        chk("hold_so", 32'(a_shift_out), 32'h0);
        a_invert = 0;
        a_shift_en = 1; a_shift_dir = 0; a_shift_in = 0;
        tick();
        chk("shl2_so", 32'(a_shift_out), 32'h1);

        // load + consume + shift in one cycle
        a_src_data = 24'h00_00_AA; a_src_load = 3'b001; a_consume = 1;
        tick();
        chk("simul_out", 32'(a_out), 32'hAA);
        chk("simul_valid", 32'(a_valid), 32'h1);
        chk("simul_so", 32'(a_shift_out), 32'h1);
        a_src_load = 3'b000; a_consume = 0; a_shift_en = 0;
        a_clear = 1; a_shift_en = 1;
        tick();
        chk("clr_keep_so", 32'(a_shift_out), 32'h1);
        chk("clr_over_shift", 32'(a_out), 32'h00);
        a_clear = 0; a_shift_en = 0;

        // WIDTH=1 instance
        b_src_data = 1; b_src_load = 1; b_invert = 1;
        tick();
        chk("w1_inv_out", 32'(b_out), 32'h0);
        chk("w1_valid", 32'(b_valid), 32'h1);
        b_src_load = 0; b_invert = 0; b_shift_en = 1; b_shift_dir = 0; b_shift_in = 1;
        tick();
        chk("w1_shl_out", 32'(b_out), 32'h1);
        chk("w1_shl_so", 32'(b_shift_out), 32'h0);
        b_shift_dir = 1; b_shift_in = 0;
        tick();
        chk("w1_shr_out", 32'(b_out), 32'h0);
        chk("w1_shr_so", 32'(b_shift_out), 32'h1);
        chk("w1_shift_valid", 32'(b_valid), 32'h1);
        b_shift_en = 0; b_consume = 1;
        tick();
        chk("w1_consume", 32'(b_valid), 32'h0);
        chk("w1_conflict", 32'(b_conflict), 32'h0);
        b_consume = 0;

        // WIDTH=16, NUM_SRC=8 instance
        c_src_data = '0;
        c_src_data[5*16 +: 16] = 16'hBEEF;
        c_src_data[7*16 +: 16] = 16'h1234;
        c_src_load = 8'b1010_0000;
        tick();
        chk("w16_conf_out", 32'(c_out), 32'hBEEF);
        chk("w16_conf_flag", 32'(c_conflict), 32'h1);
        c_src_load = 8'b1000_0000; c_invert = 1;
        tick();
        chk("w16_inv_out", 32'(c_out), 32'hEDCB);
        c_invert = 0;
        c_src_data[15:0] = 16'h8001; c_src_load = 8'b0000_0001;
        tick();
        c_src_load = '0; c_shift_en = 1; c_shift_dir = 0; c_shift_in = 0;
        tick();
        chk("w16_shl_out", 32'(c_out), 32'h0002);
        chk("w16_shl_so", 32'(c_shift_out), 32'h1);
        c_shift_dir = 1; c_shift_in = 1;
        tick();
        chk("w16_shr_out", 32'(c_out), 32'h8001);
        chk("w16_shr_so", 32'(c_shift_out), 32'h0);
        c_shift_en = 0; c_clear = 1;
        tick();
        chk("w16_clr_out", 32'(c_out), 32'h0000);
        chk("w16_clr_valid", 32'(c_valid), 32'h0);
        chk("w16_clr_conflict", 32'(c_conflict), 32'h1);
        c_clear = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
